// File: rtl/hdmi_pixel_align_if.sv
// Bus bundle for hdmi_pixel_align: primary stream, aux FIFO write side, source select and packed output.
// Status signals exist only when HDMI_PIXEL_ALIGN_STATUS_EN is defined.
interface hdmi_pixel_align_if #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int AW = 11
);
  logic              in_hsync;
  logic              in_vsync;
  logic              in_de;
  logic [23:0]       in_rgb;
  logic [XW-1:0]     in_x;
  logic [YW-1:0]     in_y;
  logic              aux_wen;
  logic [23:0]       aux_wdata;
  logic              aux_clr;
  logic              sel;
  logic [27+XW+YW:0] pack;
`ifdef HDMI_PIXEL_ALIGN_STATUS_EN
  logic              aux_full;
  logic              aux_empty;
  logic [AW:0]       aux_count;
  logic              aux_ovf;

  modport master (
    output in_hsync, in_vsync, in_de, in_rgb, in_x, in_y,
    output aux_wen, aux_wdata, aux_clr, sel,
    input  pack, aux_full, aux_empty, aux_count, aux_ovf
  );
  modport slave (
    input  in_hsync, in_vsync, in_de, in_rgb, in_x, in_y,
    input  aux_wen, aux_wdata, aux_clr, sel,
    output pack, aux_full, aux_empty, aux_count, aux_ovf
  );
`else
  modport master (
    output in_hsync, in_vsync, in_de, in_rgb, in_x, in_y,
    output aux_wen, aux_wdata, aux_clr, sel,
    input  pack
  );
  modport slave (
    input  in_hsync, in_vsync, in_de, in_rgb, in_x, in_y,
    input  aux_wen, aux_wdata, aux_clr, sel,
    output pack
  );
`endif
endinterface

// File: rtl/hdmi_pixel_align.sv
// Video alignment stage: delays the primary stream, buffers an aux stream in a show-ahead FIFO,
// selects the rgb source per frame and packs the HDMI bus. Optional status via HDMI_PIXEL_ALIGN_STATUS_EN.
module hdmi_pixel_align #(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 720,
  parameter int DELAY = 5,
  parameter int DEPTH = 2048
) (
  input logic               clk,
  input logic               rst,
  hdmi_pixel_align_if.slave bus
);
  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = 27 + XW + YW;

  logic [SW-1:0] stage_in;
  logic [SW-1:0] stage_out;
  logic [23:0]   d_rgb;
  logic          d_hsync;
  logic          d_vsync;
  logic          d_de;
  logic [XW-1:0] d_x;
  logic [YW-1:0] d_y;

  assign stage_in = {bus.in_rgb, bus.in_hsync, bus.in_vsync, bus.in_de, bus.in_x, bus.in_y};

  generate
    if (DELAY == 0) begin : g_pass
      assign stage_out = stage_in;
    end else begin : g_pipe
      logic [SW-1:0] pipe [DELAY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= stage_in;
          for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign stage_out = pipe[DELAY-1];
    end
  endgenerate

  assign {d_rgb, d_hsync, d_vsync, d_de, d_x, d_y} = stage_out;

  logic [23:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        rd;
  logic        wr;
  logic        flush;
  logic [23:0] fifo_head;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign flush     = rst || bus.aux_clr;
  assign rd        = d_de && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a write alongside a read.
  assign wr        = bus.aux_wen && (!full || rd);
  assign fifo_head = empty ? 24'h0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wr_ptr[AW-1:0]] <= bus.aux_wdata;
  end

  logic        sel_q;
  logic [23:0] o_rgb;

  // Source changes only while delayed vsync is high so a frame never mixes sources.
  always_ff @(posedge clk) begin
    if (rst)          sel_q <= 1'b1;
    else if (d_vsync) sel_q <= bus.sel;
  end

  assign o_rgb    = sel_q ? d_rgb : fifo_head;
  assign bus.pack = {clk, d_hsync, d_vsync, d_de, o_rgb, d_x, d_y};

`ifdef HDMI_PIXEL_ALIGN_STATUS_EN
  logic ovf;

  always_ff @(posedge clk) begin
    if (flush)                          ovf <= 1'b0;
    else if (bus.aux_wen && full && !rd) ovf <= 1'b1;
  end

  assign bus.aux_full  = full;
  assign bus.aux_empty = empty;
  assign bus.aux_count = count;
  assign bus.aux_ovf   = ovf;
`endif
endmodule

// File: tb/tb_hdmi_pixel_align.sv
// Self-checking bench for hdmi_pixel_align against a queue-based reference model.
module tb_hdmi_pixel_align;
  localparam int H_ACT = 1280;
  localparam int V_ACT = 720;
  localparam int DELAY = 5;
  localparam int DEPTH = 4;
  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = 28 + XW + YW;
  localparam int DE_BIT = XW + YW + 24;
  localparam int RGB_LO = XW + YW;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hdmi_pixel_align_if #(.XW(XW), .YW(YW), .AW(AW)) bif ();

  hdmi_pixel_align #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .DELAY(DELAY), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [23:0]   rgb;
    logic          hs;
    logic          vs;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } px_t;

  px_t         dq[$];
  logic [23:0] fq[$];
  logic        sel_m;
  logic        ovf_m;

  function automatic void model_reset();
    dq.delete();
    for (int i = 0; i < DELAY; i++) dq.push_back('0);
    fq.delete();
    sel_m = 1'b1;
    ovf_m = 1'b0;
  endfunction

  // Pack as seen at the falling edge, where the clk bit reads 0.
  function automatic logic [PW-1:0] exp_pack();
    px_t d;
    logic [23:0] rgb;
    d   = dq[0];
    rgb = sel_m ? d.rgb : ((fq.size() > 0) ? fq[0] : 24'h0);
    return {1'b0, d.hs, d.vs, d.de, rgb, d.x, d.y};
  endfunction

  function automatic void model_step();
    px_t d;
    px_t n;
    logic rd_m;
    logic wr_m;
    logic full_m;
    if (rst) begin
      model_reset();
      return;
    end
    d = dq[0];
    if (d.vs) sel_m = bif.sel;
    if (bif.aux_clr) begin
      fq.delete();
      ovf_m = 1'b0;
    end else begin
      rd_m   = d.de && (fq.size() > 0);
      full_m = (fq.size() == DEPTH);
      wr_m   = bif.aux_wen && (!full_m || rd_m);
      if (bif.aux_wen && full_m && !rd_m) ovf_m = 1'b1;
      if (rd_m) void'(fq.pop_front());
      if (wr_m) fq.push_back(bif.aux_wdata);
    end
    n = {bif.in_rgb, bif.in_hsync, bif.in_vsync, bif.in_de, bif.in_x, bif.in_y};
    void'(dq.pop_front());
    dq.push_back(n);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bif.in_hsync  = 1'b0;
    bif.in_vsync  = 1'b0;
    bif.in_de     = 1'b0;
    bif.in_rgb    = 24'h0;
    bif.in_x      = '0;
    bif.in_y      = '0;
    bif.aux_wen   = 1'b0;
    bif.aux_wdata = 24'h0;
    bif.aux_clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bif.pack !== {PW{1'b0}}) begin
      failures++;
      $display("[TB] FAIL reset_pack: got %h expected %h", bif.pack, {PW{1'b0}});
    end
    checks++;
    if (bif.pack !== exp_pack()) begin
      failures++;
      $display("[TB] FAIL reset_model: got %h expected %h", bif.pack, exp_pack());
    end
`ifdef HDMI_PIXEL_ALIGN_STATUS_EN
    checks++;
    if (bif.aux_empty !== 1'b1 || bif.aux_count !== '0 || bif.aux_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_status: got empty=%b count=%0d ovf=%b expected 1 0 0",
               bif.aux_empty, bif.aux_count, bif.aux_ovf);
    end
`endif
  endtask

  task automatic test_delay();
    bif.sel    = 1'b1;
    bif.in_de  = 1'b1;
    bif.in_rgb = 24'h123456;
    bif.in_x   = XW'(5);
    bif.in_y   = YW'(7);
    tick();
    drive_idle();
    for (int k = 1; k <= DELAY + 3; k++) begin
      checks++;
      if (bif.pack[DE_BIT] !== (k == DELAY)) begin
        failures++;
        $display("[TB] FAIL delay_de k=%0d: got %b expected %b", k, bif.pack[DE_BIT], (k == DELAY));
      end
      if (k == DELAY) begin
        checks++;
        if (bif.pack[RGB_LO +: 24] !== 24'h123456) begin
          failures++;
          $display("[TB] FAIL delay_rgb: got %h expected 123456", bif.pack[RGB_LO +: 24]);
        end
      end
      checks++;
      if (bif.pack !== exp_pack()) begin
        failures++;
        $display("[TB] FAIL delay_model k=%0d: got %h expected %h", k, bif.pack, exp_pack());
      end
      tick();
    end
  endtask

  task automatic test_aux();
    logic [23:0] vals [3];
    int seen;
    vals[0] = 24'hAA0000;
    vals[1] = 24'h00BB00;
    vals[2] = 24'h0000CC;
    bif.sel      = 1'b0;
    bif.in_vsync = 1'b1;
    tick();
    drive_idle();
    repeat (DELAY) tick();
    for (int i = 0; i < 3; i++) begin
      bif.aux_wen   = 1'b1;
      bif.aux_wdata = vals[i];
      tick();
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      bif.in_de = 1'b1;
      tick();
    end
    drive_idle();
    seen = 0;
    for (int k = 0; k < DELAY + 3; k++) begin
      if (bif.pack[DE_BIT] === 1'b1 && seen < 3) begin
        checks++;
        if (bif.pack[RGB_LO +: 24] !== vals[seen]) begin
          failures++;
          $display("[TB] FAIL aux_rgb%0d: got %h expected %h", seen, bif.pack[RGB_LO +: 24], vals[seen]);
        end
        seen++;
      end
      checks++;
      if (bif.pack !== exp_pack()) begin
        failures++;
        $display("[TB] FAIL aux_model k=%0d: got %h expected %h", k, bif.pack, exp_pack());
      end
      tick();
    end
    checks++;
    if (seen !== 3) begin
      failures++;
      $display("[TB] FAIL aux_de_count: got %0d expected 3", seen);
    end
    checks++;
    if (bif.pack[RGB_LO +: 24] !== 24'h000000) begin
      failures++;
      $display("[TB] FAIL aux_drained: got %h expected 000000", bif.pack[RGB_LO +: 24]);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] got [$];
    bif.aux_clr = 1'b1;
    tick();
    bif.aux_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bif.aux_wen   = 1'b1;
      bif.aux_wdata = 24'h100 + 24'(i);
      tick();
    end
    drive_idle();
`ifdef HDMI_PIXEL_ALIGN_STATUS_EN
    checks++;
    if (bif.aux_ovf !== 1'b1 || bif.aux_full !== 1'b1 || bif.aux_count !== (AW+1)'(DEPTH)) begin
      failures++;
      $display("[TB] FAIL ovf_status: got ovf=%b full=%b count=%0d expected 1 1 %0d",
               bif.aux_ovf, bif.aux_full, bif.aux_count, DEPTH);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      bif.in_de = 1'b1;
      tick();
    end
    drive_idle();
    for (int k = 0; k < DELAY + 4; k++) begin
      if (bif.pack[DE_BIT] === 1'b1) got.push_back(bif.pack[RGB_LO +: 24]);
      checks++;
      if (bif.pack !== exp_pack()) begin
        failures++;
        $display("[TB] FAIL ovf_model k=%0d: got %h expected %h", k, bif.pack, exp_pack());
      end
      tick();
    end
    checks++;
    if (got.size() != 5) begin
      failures++;
      $display("[TB] FAIL ovf_reads: got %0d reads expected 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== ((i < 4) ? 24'h100 + 24'(i) : 24'h0)) begin
          failures++;
          $display("[TB] FAIL ovf_read%0d: got %h expected %h", i, got[i],
                   ((i < 4) ? 24'h100 + 24'(i) : 24'h0));
        end
      end
    end
  endtask

  task automatic test_sel_switch();
    logic [23:0] line_rgb [12];
    int idx;
    bif.sel      = 1'b1;
    bif.in_vsync = 1'b1;
    tick();
    drive_idle();
    repeat (DELAY) tick();
    for (int k = 0; k < 12; k++) line_rgb[k] = 24'($urandom) | 24'h1;
    for (int k = 0; k < 12; k++) begin
      bif.in_de  = 1'b1;
      bif.in_rgb = line_rgb[k];
      bif.in_x   = XW'(k);
      if (k == 3) bif.sel = 1'b0;
      tick();
      idx = k + 1 - DELAY;
      if (idx >= 0) begin
        checks++;
        if (bif.pack[RGB_LO +: 24] !== line_rgb[idx]) begin
          failures++;
          $display("[TB] FAIL sel_hold%0d: got %h expected %h", idx, bif.pack[RGB_LO +: 24], line_rgb[idx]);
        end
      end
    end
    drive_idle();
    repeat (DELAY) tick();
    bif.aux_wen   = 1'b1;
    bif.aux_wdata = 24'h5A5A5A;
    tick();
    drive_idle();
    bif.in_vsync = 1'b1;
    bif.in_rgb   = 24'hC3C3C3;
    tick();
    drive_idle();
    for (int k = 0; k < DELAY + 2; k++) begin
      checks++;
      if (bif.pack !== exp_pack()) begin
        failures++;
        $display("[TB] FAIL sel_model k=%0d: got %h expected %h", k, bif.pack, exp_pack());
      end
      tick();
    end
    checks++;
    if (bif.pack[RGB_LO +: 24] !== 24'h5A5A5A) begin
      failures++;
      $display("[TB] FAIL sel_switched: got %h expected 5a5a5a", bif.pack[RGB_LO +: 24]);
    end
  endtask

  task automatic test_clear();
    bif.aux_wen   = 1'b1;
    bif.aux_wdata = 24'h3C3C3C;
    tick();
    drive_idle();
    bif.in_de = 1'b1;
    tick();
    drive_idle();
    repeat (DELAY - 1) tick();
    checks++;
    if (bif.pack[DE_BIT] !== 1'b1 || bif.pack[RGB_LO +: 24] !== 24'h5A5A5A) begin
      failures++;
      $display("[TB] FAIL clr_setup: got de=%b rgb=%h expected de=1 rgb=5a5a5a",
               bif.pack[DE_BIT], bif.pack[RGB_LO +: 24]);
    end
    bif.aux_clr   = 1'b1;
    bif.aux_wen   = 1'b1;
    bif.aux_wdata = 24'h777777;
    tick();
    drive_idle();
    checks++;
    if (bif.pack[RGB_LO +: 24] !== 24'h000000) begin
      failures++;
      $display("[TB] FAIL clr_rgb: got %h expected 000000", bif.pack[RGB_LO +: 24]);
    end
`ifdef HDMI_PIXEL_ALIGN_STATUS_EN
    checks++;
    if (bif.aux_empty !== 1'b1 || bif.aux_count !== '0) begin
      failures++;
      $display("[TB] FAIL clr_status: got empty=%b count=%0d expected 1 0", bif.aux_empty, bif.aux_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      bif.in_de     = 1'b1;
      bif.in_hsync  = 1'($urandom);
      bif.in_rgb    = 24'($urandom);
      bif.in_x      = XW'($urandom);
      bif.in_y      = YW'($urandom);
      bif.aux_wen   = 1'b1;
      bif.aux_wdata = 24'($urandom);
      tick();
    end
    bif.sel = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    drive_idle();
    checks++;
    if (bif.pack !== {PW{1'b0}}) begin
      failures++;
      $display("[TB] FAIL rstmid_pack: got %h expected %h", bif.pack, {PW{1'b0}});
    end
`ifdef HDMI_PIXEL_ALIGN_STATUS_EN
    checks++;
    if (bif.aux_empty !== 1'b1 || bif.aux_count !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_status: got empty=%b count=%0d expected 1 0", bif.aux_empty, bif.aux_count);
    end
`endif
    bif.aux_wen   = 1'b1;
    bif.aux_wdata = 24'h0F0F0F;
    bif.in_rgb    = 24'hABCDEF;
    tick();
    drive_idle();
    repeat (DELAY - 1) tick();
    checks++;
    if (bif.pack[RGB_LO +: 24] !== 24'hABCDEF) begin
      failures++;
      $display("[TB] FAIL rstmid_sel: got %h expected abcdef", bif.pack[RGB_LO +: 24]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst           = ($urandom_range(0, 63) == 0);
      bif.in_hsync  = 1'($urandom);
      bif.in_vsync  = ($urandom_range(0, 15) == 0);
      bif.in_de     = 1'($urandom);
      bif.in_rgb    = 24'($urandom);
      bif.in_x      = XW'($urandom);
      bif.in_y      = YW'($urandom);
      bif.aux_wen   = 1'($urandom);
      bif.aux_wdata = 24'($urandom);
      bif.aux_clr   = ($urandom_range(0, 15) == 0);
      bif.sel       = 1'($urandom);
      tick();
      checks++;
      if (bif.pack !== exp_pack()) begin
        failures++;
        $display("[TB] FAIL rand_pack k=%0d: got %h expected %h", k, bif.pack, exp_pack());
      end
`ifdef HDMI_PIXEL_ALIGN_STATUS_EN
      checks++;
      if (bif.aux_count !== (AW+1)'(fq.size()) || bif.aux_full !== (fq.size() == DEPTH) ||
          bif.aux_empty !== (fq.size() == 0) || bif.aux_ovf !== ovf_m) begin
        failures++;
        $display("[TB] FAIL rand_status k=%0d: got count=%0d full=%b empty=%b ovf=%b expected %0d %b %b %b",
                 k, bif.aux_count, bif.aux_full, bif.aux_empty, bif.aux_ovf,
                 fq.size(), (fq.size() == DEPTH), (fq.size() == 0), ovf_m);
      end
`endif
    end
    rst = 1'b0;
    drive_idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bif.sel  = 1'b1;
    drive_idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_delay();
    test_aux();
    test_overflow();
    test_sel_switch();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
